// File: rtl/mem_wait_responder.sv
// Wait-state data memory answering the core's stall handshake: each access holds
// stall for WAIT_CYCLES cycles, then returns a registered one-cycle response.
module mem_wait_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err
);

  // state  | meaning
  // S_IDLE | no access outstanding; stall follows req_valid
  // S_BUSY | counting down the remaining wait cycles
  // S_DONE | one-cycle response, incoming req_valid ignored

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES >= 2) ? CW'(WAIT_CYCLES - 2) : '0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          acc_en, acc_we, acc_err;
  logic [31:0]   acc_addr, acc_wdata;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;

  // With a single wait cycle the access happens on the accept edge, so it
  // must use the live request rather than the not-yet-latched copy.
  always_comb begin
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == S_IDLE) begin
      acc_en    = req_valid && (WAIT_CYCLES == 1);
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else if (state_q == S_BUSY) begin
      acc_en = (cnt_q == '0);
    end
    acc_idx = acc_addr[AW+1:2];
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = (WAIT_CYCLES == 1) ? S_DONE : S_BUSY;
        cnt_d   = CNT_INIT;
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE:  stall      = req_valid && !rst;
      S_BUSY:  stall      = 1'b1;
      S_DONE:  resp_valid = 1'b1;
      default: stall      = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (acc_en) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'h0 : mem_q[acc_idx];
      end
    end
  end

  // Contents survive reset; reset only blocks an access that would land this edge.
  always_ff @(posedge clk) begin
    if (!rst && acc_en && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign rdata    = rdata_q;
  assign resp_err = err_q;

endmodule
